// File: rtl/image_line_ctrl.sv
// image_line_ctrl
//   Front-end for the 3x3 convolution datapath. An 8-bit raster pixel stream
//   is written into four rotating line buffers. Once three complete lines are
//   held, one 3x3 window per cycle is read out for a full line. Each finished
//   line pulses o_intr so the producer can refill the released buffer.
//
//   Build option: IMG_CTRL_ZERO_PAD_EN
//     defined   -> columns past the right edge read as zero
//     undefined -> the right-edge pixel is replicated
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               synchronous active-high reset
//   i_pixel_data        incoming pixel (raster order)
//   i_pixel_data_valid  write strobe, taken only while o_pixel_ready=1
//   o_pixel_ready       storage not full
//   o_pixel_data        registered 3x3 window; pixel (row k, col j) at
//                       [(3k+j)*PIX_W +: PIX_W]
//   o_pixel_data_valid  o_pixel_data valid this cycle
//   o_intr              one-cycle pulse with the last window of a line
//
// Read FSM
//   state | meaning
//   IDLE  | waiting for three full lines (rd_ptr held at 0)
//   READ  | emitting one window per cycle across the line
module image_line_ctrl #(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_data_valid,
  output logic               o_pixel_ready,
  output logic [9*PIX_W-1:0] o_pixel_data,
  output logic               o_pixel_data_valid,
  output logic               o_intr
);

  localparam int PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CNT_W = $clog2(4*IMG_WIDTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(IMG_WIDTH - 1);
  localparam logic [PTR_W:0]   LAST_COL  = (PTR_W+1)'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(4*IMG_WIDTH);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(3*IMG_WIDTH);

  typedef enum logic {IDLE, READ} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0]   lb [4][IMG_WIDTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [1:0]         wr_sel, rd_sel;
  logic [CNT_W-1:0]   total_cnt;
  logic               wr_en, rd_en, rd_last;
  logic [9*PIX_W-1:0] win;

  assign o_pixel_ready = (total_cnt < FULL_CNT);
  assign wr_en         = i_pixel_data_valid & o_pixel_ready;
  assign rd_last       = (rd_ptr == LAST_PTR);

  // Buffer RAM has no reset; stale contents are never read because reads
  // only start once three fresh lines have been counted in.
  always_ff @(posedge i_clk) begin
    if (wr_en) lb[wr_sel][wr_ptr] <= i_pixel_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      wr_sel <= '0;
    end else if (wr_en) begin
      if (wr_ptr == LAST_PTR) begin
        wr_ptr <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      total_cnt <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   total_cnt <= total_cnt + 1'b1;
        2'b01:   total_cnt <= total_cnt - 1'b1;
        default: total_cnt <= total_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: if (total_cnt >= START_CNT) state_nxt = READ;
      READ: begin
        rd_en = 1'b1;
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row k comes from buffer rd_sel+k (mod 4); column j from rd_ptr+j, with
  // the extra pointer bit catching columns that run past the right edge.
  for (genvar k = 0; k < 3; k++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      logic [1:0]     row;
      logic [PTR_W:0] col;
      assign row = rd_sel + 2'(k);
      assign col = {1'b0, rd_ptr} + (PTR_W+1)'(j);
`ifdef IMG_CTRL_ZERO_PAD_EN
      assign win[(3*k+j)*PIX_W +: PIX_W] =
        (col > LAST_COL) ? '0 : lb[row][col[PTR_W-1:0]];
`else
      assign win[(3*k+j)*PIX_W +: PIX_W] =
        lb[row][(col > LAST_COL) ? LAST_PTR : col[PTR_W-1:0]];
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr             <= '0;
      rd_sel             <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      if (rd_en) begin
        o_pixel_data <= win;
        if (rd_last) begin
          rd_ptr <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      o_pixel_data_valid <= rd_en;
      // registered alongside the last window so both appear together
      o_intr             <= rd_en & rd_last;
    end
  end

endmodule

// File: tb/tb_image_line_ctrl.sv
module tb_image_line_ctrl;
  localparam int W = 8;
  localparam logic [71:0] FIRST_WIN =
    {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
`ifdef IMG_CTRL_ZERO_PAD_EN
  localparam logic [23:0] LAST_ROW0 = 24'h000007;
`else
  localparam logic [23:0] LAST_ROW0 = 24'h070707;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_v = 1'b0;
  logic        pix_ready;
  logic [71:0] pix_out;
  logic        pix_out_v;
  logic        intr;

  image_line_ctrl #(.IMG_WIDTH(W), .PIX_W(8)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (din),
    .i_pixel_data_valid (din_v),
    .o_pixel_ready      (pix_ready),
    .o_pixel_data       (pix_out),
    .o_pixel_data_valid (pix_out_v),
    .o_intr             (intr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  hist[$];   // every accepted pixel since reset, in arrival order
  int          acc      = 0;
  int          win_cnt  = 0;
  logic [71:0] last_win = '0;
  bit          saw_full = 0;
  bit          saw_drop = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Window for the given output line and column: rows are image lines
  // line..line+2 of the accepted stream.
  function automatic logic [71:0] model_win(input int line, input int col);
    logic [71:0] w = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        int   c   = col + j;
        bit   pad = 0;
        int   idx;
        if (c > W-1) begin
`ifdef IMG_CTRL_ZERO_PAD_EN
          pad = 1;
`endif
          c = W-1;
        end
        idx = (line + k)*W + c;
        w[(3*k+j)*8 +: 8] = (pad || idx >= hist.size()) ? 8'h00 : hist[idx];
      end
    end
    return w;
  endfunction

  task automatic monitor();
    int line, col;
    if (pix_out_v) begin
      line = win_cnt / W;
      col  = win_cnt % W;
      chk("enough_data", 72'(acc >= (line+3)*W), 72'd1);
      chk("window", pix_out, model_win(line, col));
      chk("intr", 72'(intr), 72'(col == W-1));
      if (col == W-1) last_win = pix_out;
      win_cnt++;
    end else begin
      chk("intr_idle", 72'(intr), 72'd0);
    end
    chk("ready", 72'(pix_ready), 72'((acc - win_cnt) < 4*W));
    if (!pix_ready) saw_full = 1;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    monitor();
    din_v = v;
    din   = d;
    if (v && pix_ready) begin
      hist.push_back(d);
      acc++;
    end else if (v) begin
      saw_drop = 1;
    end
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    din_v = 1'b0;
    @(negedge clk);
    chk("rst_valid", 72'(pix_out_v), 72'd0);
    chk("rst_intr",  72'(intr), 72'd0);
    chk("rst_data",  pix_out, 72'd0);
    chk("rst_ready", 72'(pix_ready), 72'd1);
    rst = 1'b0;
    hist.delete();
    acc     = 0;
    win_cnt = 0;
  endtask

  task automatic run_basic();
    int lat;
    for (int i = 0; i < 23; i++) step(1'b1, 8'(i));
    repeat (6) begin
      step(1'b0, 8'h00);
      chk("no_early_valid", 72'(pix_out_v), 72'd0);
    end
    step(1'b1, 8'd23);
    lat = 0;
    do begin
      step(1'b0, 8'h00);
      lat++;
    end while (!pix_out_v && lat < 20);
    chk("first_latency", 72'(lat), 72'd3);
    chk("first_win", pix_out, FIRST_WIN);
    repeat (12) step(1'b0, 8'h00);
    chk("lines_done", 72'(win_cnt), 72'(W));
    chk("last_row0", 72'(last_win[23:0]), 72'(LAST_ROW0));
  endtask

  initial begin
    int lim;
    reset_dut();
    run_basic();

    reset_dut();
    saw_full = 0;
    saw_drop = 0;
    repeat (150) step(1'b1, 8'($urandom));
    repeat (300) step(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (40) step(1'b0, 8'h00);
    chk("ready_low_seen", 72'(saw_full), 72'd1);
    chk("drop_seen", 72'(saw_drop), 72'd1);
    chk("all_lines", 72'(win_cnt), 72'((acc/W - 2)*W));

    reset_dut();
    for (int i = 0; i < 24; i++) step(1'b1, 8'($urandom));
    lim = 0;
    while (win_cnt < 4 && lim < 40) begin
      step(1'b0, 8'h00);
      lim++;
    end
    chk("reach_mid", 72'(win_cnt), 72'd4);
    reset_dut();
    repeat (10) begin
      step(1'b0, 8'h00);
      chk("idle_after_rst", 72'(pix_out_v), 72'd0);
    end
    run_basic();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
